// File: rtl/control_word_sequencer.sv
// control_word_sequencer: arbitrates five level requesters onto the 8-bit
// datapath control word. A granted word is held for HOLD_CYCLES, then the idle
// word is forced for GUARD_CYCLES before the next grant.
// Optional build macro: CTRL_SEQ_ROUND_ROBIN_EN (round-robin arbitration;
// fixed priority with req_i[0] highest when undefined).
//
// state    | meaning
// S_IDLE   | no grant, sampling requests every cycle
// S_ACTIVE | winner's word and grant driven, counting hold cycles
// S_GUARD  | idle word driven, busy held, requests ignored
module control_word_sequencer #(
   parameter int         HOLD_CYCLES  = 4,
   parameter int         GUARD_CYCLES = 1,
   parameter logic [7:0] WORD_0       = 8'hED,
   parameter logic [7:0] WORD_1       = 8'h3A,
   parameter logic [7:0] WORD_2       = 8'hE9,
   parameter logic [7:0] WORD_3       = 8'h3A,
   parameter logic [7:0] WORD_4       = 8'h50,
   parameter logic [7:0] IDLE_WORD    = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] req_i,
   output logic [4:0] grant_o,
   output logic [7:0] ctrl_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       abort_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_GUARD  = 2'd2;

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic [2:0]    win_q, win_d;
   logic [4:0]    grant_q, grant_d;
   logic [7:0]    ctrl_q, ctrl_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          abort_q, abort_d;
   logic          pick_valid;
   logic [2:0]    pick_idx;
   logic          hold_end;
`ifdef CTRL_SEQ_ROUND_ROBIN_EN
   logic [2:0]    ptr_q, ptr_d;
`endif

   function automatic logic [7:0] word_of(input logic [2:0] idx);
      case (idx)
         3'd0:    word_of = WORD_0;
         3'd1:    word_of = WORD_1;
         3'd2:    word_of = WORD_2;
         3'd3:    word_of = WORD_3;
         3'd4:    word_of = WORD_4;
         default: word_of = IDLE_WORD;
      endcase
   endfunction

   // Arbitration: pick the winning requester among the current requests.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = 3'd0;
`ifdef CTRL_SEQ_ROUND_ROBIN_EN
      // Walk the search order backwards so the nearest candidate after the
      // pointer is assigned last and wins.
      for (int k = 5; k >= 1; k--) begin
         logic [2:0] j;
         j = 3'((int'(ptr_q) + k) % 5);
         if (req_i[j]) begin
            pick_valid = 1'b1;
            pick_idx   = j;
         end
      end
`else
      for (int i = 4; i >= 0; i--) begin
         if (req_i[3'(i)]) begin
            pick_valid = 1'b1;
            pick_idx   = 3'(i);
         end
      end
`endif
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gcnt_d   = gcnt_q;
      win_d    = win_q;
      grant_d  = grant_q;
      ctrl_d   = ctrl_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      hold_end = (cnt_q == HOLD_LAST);
`ifdef CTRL_SEQ_ROUND_ROBIN_EN
      ptr_d    = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            grant_d = 5'b00000;
            ctrl_d  = IDLE_WORD;
            busy_d  = 1'b0;
            if (pick_valid) begin
               state_d = S_ACTIVE;
               win_d   = pick_idx;
               grant_d = 5'b00001 << pick_idx;
               ctrl_d  = word_of(pick_idx);
               busy_d  = 1'b1;
               cnt_d   = '0;
`ifdef CTRL_SEQ_ROUND_ROBIN_EN
               ptr_d   = pick_idx;
`endif
            end
         end
         S_ACTIVE: begin
            // A release on the final hold cycle is reported as normal completion.
            if (hold_end || !req_i[win_q]) begin
               grant_d = 5'b00000;
               ctrl_d  = IDLE_WORD;
               done_d  = hold_end;
               abort_d = !hold_end;
               gcnt_d  = '0;
               if (GUARD_CYCLES == 0) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_GUARD;
                  busy_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GUARD: begin
            if (gcnt_q == GUARD_LAST) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 5'b00000;
            ctrl_d  = IDLE_WORD;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         win_q   <= 3'd0;
         grant_q <= 5'b00000;
         ctrl_q  <= IDLE_WORD;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
`ifdef CTRL_SEQ_ROUND_ROBIN_EN
         ptr_q   <= 3'd4;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         win_q   <= win_d;
         grant_q <= grant_d;
         ctrl_q  <= ctrl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abort_q <= abort_d;
`ifdef CTRL_SEQ_ROUND_ROBIN_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign grant_o = grant_q;
   assign ctrl_o  = ctrl_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign abort_o = abort_q;

endmodule
